// File: rtl/writeback_sequencer_if.sv
// writeback_sequencer_if: unit result bus and output-memory write port of the writeback sequencer.
interface writeback_sequencer_if #(
    parameter int NUM_UNITS = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12
);
    logic [NUM_UNITS-1:0]        unit_valid;
    logic [NUM_UNITS*DATA_W-1:0] unit_data;
    logic [NUM_UNITS-1:0]        unit_ack;
    logic                        mem_wr_en;
    logic [ADDR_W-1:0]           mem_wr_addr;
    logic [DATA_W-1:0]           mem_wr_data;
    logic                        mem_ready;

    modport master (
        input  unit_valid, unit_data, mem_ready,
        output unit_ack, mem_wr_en, mem_wr_addr, mem_wr_data
    );
    modport slave (
        output unit_valid, unit_data, mem_ready,
        input  unit_ack, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/writeback_sequencer.sv
// writeback_sequencer: drains valid unit results to the output memory in ascending unit order each round.
module writeback_sequencer #(
    parameter int NUM_UNITS = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  writeback_en,
    input  logic                  writeback_rst,
    writeback_sequencer_if.master wb,
    output logic                  busy,
    output logic                  drain_done
);
    localparam int IDX_W = $clog2(NUM_UNITS);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    state_t               state, state_nx;
    logic [NUM_UNITS-1:0] pending, pending_nx;
    logic [IDX_W-1:0]     sel, sel_nx, low;
    logic [ADDR_W-1:0]    round_base, round_base_nx;
    logic                 in_write, accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pending    <= '0;
            sel        <= '0;
            round_base <= '0;
        end else begin
            state      <= state_nx;
            pending    <= pending_nx;
            sel        <= sel_nx;
            round_base <= round_base_nx;
        end
    end

    // Highest index scanned first so the lowest set bit wins.
    always_comb begin
        low = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--)
            if (pending[i]) low = IDX_W'(i);
    end

    assign in_write = state == WRITE;
    assign accept   = in_write && wb.mem_ready && !writeback_rst;

    always_comb begin
        state_nx      = state;
        pending_nx    = pending;
        sel_nx        = sel;
        round_base_nx = round_base;
        if (writeback_rst) begin
            state_nx      = IDLE;
            pending_nx    = '0;
            round_base_nx = '0;
        end else begin
            case (state)
                IDLE: if (writeback_en) begin
                    pending_nx = wb.unit_valid;
                    state_nx   = SCAN;
                end
                SCAN: begin
                    state_nx = pending == '0 ? DONE : WRITE;
                    sel_nx   = pending == '0 ? sel : low;
                end
                WRITE: if (wb.mem_ready) begin
                    pending_nx[sel] = 1'b0;
                    state_nx        = SCAN;
                end
                default: begin
                    round_base_nx = round_base + ADDR_W'(NUM_UNITS);
                    state_nx      = IDLE;
                end
            endcase
        end
    end

    // A sync clear during an accepting write suppresses the ack; the unit keeps its result.
    assign wb.mem_wr_en   = in_write;
    assign wb.mem_wr_addr = in_write ? round_base + ADDR_W'(sel) : '0;
    assign wb.mem_wr_data = in_write ? wb.unit_data[int'(sel)*DATA_W +: DATA_W] : '0;
    assign wb.unit_ack    = accept ? NUM_UNITS'(1) << sel : '0;
    assign busy           = state != IDLE;
    assign drain_done     = state == DONE && !writeback_rst;
endmodule
